// File: rtl/instr_encoder.sv
// RV32I OP/OP-IMM instruction encoder with a single output register and auto-incrementing write address.
// Optional feature: define ENC_IMM_CHECK_EN to reject immediates that do not fit the encoded field.

`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`define ALU_FUNCT_ADD   4'd0
`define ALU_FUNCT_SUB   4'd1
`define ALU_FUNCT_SLL   4'd2
`define ALU_FUNCT_SLT   4'd3
`define ALU_FUNCT_SLTU  4'd4
`define ALU_FUNCT_XOR   4'd5
`define ALU_FUNCT_SRL   4'd6
`define ALU_FUNCT_SRA   4'd7
`define ALU_FUNCT_OR    4'd8
`define ALU_FUNCT_AND   4'd9
`endif
`ifndef INSTR_REG_WIDTH
`define INSTR_REG_WIDTH 5
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module instr_encoder #(
  parameter int N      = 32,
  parameter int ADDR_W = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [`ALU_FUNCT_WIDTH-1:0] i_alu_funct,
  input  logic                        i_use_imm,
  input  logic [`INSTR_REG_WIDTH-1:0] i_rs1,
  input  logic [`INSTR_REG_WIDTH-1:0] i_rs2,
  input  logic [`INSTR_REG_WIDTH-1:0] i_rd,
  input  logic [N-1:0]                i_immed,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [`INSTR_WIDTH-1:0]     o_instr,
  output logic [ADDR_W-1:0]           o_wr_addr,
  output logic                        o_enc_err,
  output logic [ADDR_W:0]             o_count
);

  localparam logic [6:0]              OPC_OP     = 7'b0110011;
  localparam logic [6:0]              OPC_OP_IMM = 7'b0010011;
  localparam logic [`INSTR_WIDTH-1:0] NOP_WORD   = 32'h0000_0013;
`ifdef ENC_IMM_CHECK_EN
  localparam logic IMM_CHECK = 1'b1;
`else
  localparam logic IMM_CHECK = 1'b0;
`endif

  logic                    r_out_valid;
  logic [`INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic                    r_enc_err;
  logic [ADDR_W:0]         r_count;

  logic [2:0]              w_f3;
  logic [6:0]              w_f7;
  logic                    w_known;
  logic                    w_shift;
  logic                    w_is_sub;
  logic                    w_imm_fits;
  logic                    w_shamt_fits;
  logic                    w_err;
  logic [`INSTR_WIDTH-1:0] w_word;
  logic                    w_accept;
  logic                    w_xfer;

  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_xfer     = r_out_valid && i_out_ready;

  // Range checks are always computed; IMM_CHECK decides whether they can raise an error.
  assign w_imm_fits   = (i_immed == {{(N-12){i_immed[11]}}, i_immed[11:0]});
  assign w_shamt_fits = (i_immed[N-1:5] == '0);

  // Field lookup for the requested ALU operation.
  always_comb begin
    w_f3     = 3'b000;
    w_f7     = 7'b0000000;
    w_known  = 1'b1;
    w_shift  = 1'b0;
    w_is_sub = 1'b0;
    case (i_alu_funct)
      `ALU_FUNCT_ADD:  w_f3 = 3'b000;
      `ALU_FUNCT_SUB:  begin w_f3 = 3'b000; w_f7 = 7'b0100000; w_is_sub = 1'b1; end
      `ALU_FUNCT_SLL:  begin w_f3 = 3'b001; w_shift = 1'b1; end
      `ALU_FUNCT_SLT:  w_f3 = 3'b010;
      `ALU_FUNCT_SLTU: w_f3 = 3'b011;
      `ALU_FUNCT_XOR:  w_f3 = 3'b100;
      `ALU_FUNCT_SRL:  begin w_f3 = 3'b101; w_shift = 1'b1; end
      `ALU_FUNCT_SRA:  begin w_f3 = 3'b101; w_f7 = 7'b0100000; w_shift = 1'b1; end
      `ALU_FUNCT_OR:   w_f3 = 3'b110;
      `ALU_FUNCT_AND:  w_f3 = 3'b111;
      default:         w_known = 1'b0;
    endcase
  end

  // Word assembly; any unencodable request becomes ADDI x0,x0,0.
  always_comb begin
    w_err = !w_known || (w_is_sub && i_use_imm) ||
            (IMM_CHECK && i_use_imm && (!w_imm_fits || (w_shift && !w_shamt_fits)));
    if (w_err) begin
      w_word = NOP_WORD;
    end else if (!i_use_imm) begin
      w_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OPC_OP};
    end else if (w_shift) begin
      w_word = {w_f7, i_immed[4:0], i_rs1, w_f3, i_rd, OPC_OP_IMM};
    end else begin
      w_word = {i_immed[11:0], i_rs1, w_f3, i_rd, OPC_OP_IMM};
    end
  end

  // Output register plus address/count bookkeeping; clear beats a simultaneous transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_wr_addr   <= '0;
      r_enc_err   <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_instr     <= w_word;
        r_enc_err   <= w_err;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      if (i_clear) begin
        r_wr_addr <= '0;
        r_count   <= '0;
      end else if (w_xfer) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
        if (r_count != '1) begin
          r_count <= r_count + (ADDR_W+1)'(1);
        end else begin
          r_count <= r_count;
        end
      end else begin
        r_wr_addr <= r_wr_addr;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_instr     = r_instr;
  assign o_wr_addr   = r_wr_addr;
  assign o_enc_err   = r_enc_err;
  assign o_count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven, scoreboarded bench for instr_encoder (ADDR_W=4 to exercise address wrap and count saturation).
`timescale 1ns/1ps

module tb_instr_encoder;

  localparam int AW = 4;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR_ = 4'd5, SRL = 4'd6, SRA = 4'd7, OR_ = 4'd8, AND_ = 4'd9;

  typedef struct {
    logic [3:0]  op;
    logic        ui;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] ex;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, enc_err, use_imm = 1'b0;
  logic [3:0]    alu_funct = 4'd0;
  logic [4:0]    rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic [31:0]   immed = 32'd0, instr;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   count;

  int total = 0, bad = 0;
  vec_t tbl[14];
  exp_t q[$];
  exp_t cur_exp;
  logic mon_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW:0]   m_count = '0;

  instr_encoder #(.N(32), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_alu_funct(alu_funct), .i_use_imm(use_imm), .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd),
    .i_immed(immed), .o_out_valid(out_valid), .i_out_ready(out_ready), .o_instr(instr),
    .o_wr_addr(wr_addr), .o_enc_err(enc_err), .o_count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard: check current outputs, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'((q.size() == 0) || out_ready));
      chk("count", 64'(count), 64'(m_count));
      if (q.size() != 0) begin
        chk("instr", 64'(instr), 64'(q[0].instr));
        chk("enc_err", 64'(enc_err), 64'(q[0].err));
        chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      end
      if (rst) begin
        q.delete();
        m_addr  = '0;
        m_count = '0;
      end else begin
        logic xfer, acc;
        xfer = (q.size() != 0) && out_ready;
        acc  = in_valid && ((q.size() == 0) || out_ready);
        if (xfer) void'(q.pop_front());
        if (clear) begin
          m_addr  = '0;
          m_count = '0;
        end else if (xfer) begin
          m_addr = m_addr + 1'b1;
          if (m_count != 5'h1F) m_count = m_count + 1'b1;
        end
        if (acc) q.push_back(cur_exp);
      end
    end
  end

  task automatic send(input int idx);
    int n;
    alu_funct = tbl[idx].op;  use_imm = tbl[idx].ui;
    rs1 = tbl[idx].rs1;  rs2 = tbl[idx].rs2;  rd = tbl[idx].rd;  immed = tbl[idx].imm;
    cur_exp.instr = tbl[idx].ex;  cur_exp.err = tbl[idx].ee;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    tbl[0]  = '{ADD,  1'b0, 5'd1,  5'd2,  5'd3,  32'h0000_0000, 32'h0020_81B3, 1'b0};
    tbl[1]  = '{ADD,  1'b1, 5'd0,  5'd0,  5'd5,  32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0};
    tbl[2]  = '{SRA,  1'b1, 5'd7,  5'd0,  5'd6,  32'h0000_0004, 32'h4043_D313, 1'b0};
    tbl[3]  = '{SUB,  1'b1, 5'd1,  5'd0,  5'd2,  32'h0000_0001, 32'h0000_0013, 1'b1};
    tbl[4]  = '{SUB,  1'b0, 5'd1,  5'd2,  5'd3,  32'h0000_0000, 32'h4020_81B3, 1'b0};
    tbl[5]  = '{4'hF, 1'b0, 5'd1,  5'd2,  5'd3,  32'h0000_0000, 32'h0000_0013, 1'b1};
    tbl[6]  = '{AND_, 1'b0, 5'd31, 5'd31, 5'd31, 32'h0000_0000, 32'h01FF_FFB3, 1'b0};
    tbl[7]  = '{XOR_, 1'b1, 5'd2,  5'd0,  5'd1,  32'h0000_07FF, 32'h7FF1_4093, 1'b0};
    tbl[8]  = '{SLL,  1'b1, 5'd1,  5'd0,  5'd1,  32'h0000_001F, 32'h01F0_9093, 1'b0};
    tbl[9]  = '{SLTU, 1'b0, 5'd3,  5'd4,  5'd2,  32'h0000_0000, 32'h0041_B133, 1'b0};
    tbl[10] = '{SLT,  1'b1, 5'd3,  5'd0,  5'd2,  32'hFFFF_F800, 32'h8001_A113, 1'b0};
`ifdef ENC_IMM_CHECK_EN
    tbl[11] = '{ADD,  1'b1, 5'd0,  5'd0,  5'd0,  32'h0000_0800, 32'h0000_0013, 1'b1};
    tbl[12] = '{SRL,  1'b1, 5'd0,  5'd0,  5'd0,  32'h0000_0021, 32'h0000_0013, 1'b1};
    tbl[13] = '{OR_,  1'b1, 5'd0,  5'd0,  5'd0,  32'h0000_1000, 32'h0000_0013, 1'b1};
`else
    tbl[11] = '{ADD,  1'b1, 5'd0,  5'd0,  5'd0,  32'h0000_0800, 32'h8000_0013, 1'b0};
    tbl[12] = '{SRL,  1'b1, 5'd0,  5'd0,  5'd0,  32'h0000_0021, 32'h0010_5013, 1'b0};
    tbl[13] = '{OR_,  1'b1, 5'd0,  5'd0,  5'd0,  32'h0000_1000, 32'h0000_6013, 1'b0};
`endif

    idle(2);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_enc_err", 64'(enc_err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // Whole table back-to-back, then drain.
    for (int i = 0; i < 14; i++) send(i);
    idle(2);

    // Stall: memory not ready for 3 cycles while a second request waits.
    out_ready = 1'b0;
    send(2);
    fork
      send(9);
      begin idle(3); out_ready = 1'b1; end
    join
    idle(2);

    // Address wrap: 17 back-to-back transfers from a cleared state.
    clear = 1'b1; idle(1); clear = 1'b0;
    for (int i = 0; i < 17; i++) send(i % 14);
    idle(2);
    chk("count_17", 64'(count), 64'd17);
    chk("wr_addr_wrap", 64'(wr_addr), 64'd1);
    clear = 1'b1; idle(1); clear = 1'b0;
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_addr", 64'(wr_addr), 64'd0);

    // Clear coincident with a transfer wins.
    send(0);
    clear = 1'b1;
    send(1);
    clear = 1'b0;
    idle(2);
    chk("clear_vs_xfer_count", 64'(count), 64'd1);

    // Saturate the 5-bit transfer count.
    for (int i = 0; i < 40; i++) send(i % 14);
    idle(2);
    chk("count_sat", 64'(count), 64'h1F);

    // Reset while a word is stalled at the output.
    out_ready = 1'b0;
    send(6);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
